// File: rtl/comparador_pkg.sv
// comparador_pkg: shared width default and flag bundle for the comparator
package comparador_pkg;
   localparam int WIDTH_DEF = 32;
   typedef struct packed {
      logic eq;
      logic lt_u;
      logic lt_s;
   } cmp_flags_t;
endpackage

// File: rtl/comparador_core.sv
// comparador_core: combinational equality and signed/unsigned less-than
module comparador_core
   import comparador_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] reg1,
   input  logic [WIDTH-1:0] reg2,
   output cmp_flags_t       flags
);
   logic lt_u;
   assign lt_u       = reg1 < reg2;
   assign flags.eq   = reg1 == reg2;
   assign flags.lt_u = lt_u;
   // differing sign bits decide alone; otherwise the unsigned order matches signed
   assign flags.lt_s = (reg1[WIDTH-1] != reg2[WIDTH-1]) ? reg1[WIDTH-1] : lt_u;
endmodule

// File: rtl/comparador.sv
// comparador: branch comparator with zero-latency flags and a one-cycle registered copy
module comparador
   import comparador_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] reg1,
   input  logic [WIDTH-1:0] reg2,
   input  logic             in_valid,
   output logic             Comparador_Salida,
   output logic             lt_u,
   output logic             lt_s,
   output logic             eq_q,
   output logic             lt_u_q,
   output logic             lt_s_q,
   output logic             out_valid
);
   cmp_flags_t flags, flags_q;
   comparador_core #(.WIDTH(WIDTH)) u_core (
      .reg1  (reg1),
      .reg2  (reg2),
      .flags (flags)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (in_valid) flags_q <= flags;
         out_valid <= in_valid;
      end
   end
   assign Comparador_Salida = flags.eq;
   assign lt_u              = flags.lt_u;
   assign lt_s              = flags.lt_s;
   assign eq_q              = flags_q.eq;
   assign lt_u_q            = flags_q.lt_u;
   assign lt_s_q            = flags_q.lt_s;
endmodule

// File: tb/tb_comparador.sv
// tb_comparador: vector table, sweeps and scoreboarded registered-path sequences
module tb_comparador;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] reg1, reg2;
   logic        in_valid;
   logic        Comparador_Salida, lt_u, lt_s, eq_q, lt_u_q, lt_s_q, out_valid;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [2:0]  sb[$];
   logic [2:0]  hold;
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  exp;
   } vec_t;
   vec_t tbl[7];
   comparador #(.WIDTH(32)) dut (
      .clk               (clk),
      .reset             (reset),
      .reg1              (reg1),
      .reg2              (reg2),
      .in_valid          (in_valid),
      .Comparador_Salida (Comparador_Salida),
      .lt_u              (lt_u),
      .lt_s              (lt_s),
      .eq_q              (eq_q),
      .lt_u_q            (lt_u_q),
      .lt_s_q            (lt_s_q),
      .out_valid         (out_valid)
   );
   always #5 clk = ~clk;
   function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b);
      return {a == b, a < b, $signed(a) < $signed(b)};
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic comb(input string name, input logic [31:0] a, input logic [31:0] b, input logic [2:0] exp);
      reg1 = a;
      reg2 = b;
      #5;
      chk(name, {29'd0, Comparador_Salida, lt_u, lt_s}, {29'd0, exp});
   endtask
   // one clock of the registered path; expected flags go through the scoreboard
   task automatic step(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b);
      logic exp_v;
      reset    = r;
      in_valid = v;
      reg1     = a;
      reg2     = b;
      exp_v    = v && !r;
      if (exp_v) sb.push_back(model(a, b));
      @(posedge clk);
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      if (r) hold = 3'b000;
      else if (exp_v && sb.size() > 0) hold = sb.pop_front();
      chk("flags_q", {29'd0, eq_q, lt_u_q, lt_s_q}, {29'd0, hold});
   endtask
   initial begin
      tbl[0] = '{32'h0000_0000, 32'h0000_0000, 3'b100};
      tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100};
      tbl[2] = '{32'h8000_0000, 32'h0000_0000, 3'b001};
      tbl[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b010};
      tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b001};
      tbl[5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b011};
      tbl[6] = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b010};
      reset    = 1'b0;
      in_valid = 1'b0;
      reg1     = '0;
      reg2     = '0;
      hold     = 3'b000;
      for (int k = 0; k < 100; k++) comb("eq_sweep", k, k, 3'b100);
      for (int k = 0; k < 100; k++) comb("off1_sweep", k, k + 1, 3'b011);
      for (int i = 0; i < 7; i++) comb($sformatf("edge[%0d]", i), tbl[i].a, tbl[i].b, tbl[i].exp);
      for (int i = 0; i < 32; i++) begin
         reg1 = 32'hA5A5_5A5A;
         reg2 = 32'hA5A5_5A5A ^ (32'd1 << i);
         #1;
         chk($sformatf("bitdiff[%0d]", i), {31'd0, Comparador_Salida}, 32'd0);
      end
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 32'd0, 32'd0);
      step(1'b1, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b1, 32'd5, 32'd5);
      chk("eq_q_after_valid", {31'd0, eq_q}, 32'd1);
      step(1'b0, 1'b0, 32'd3, 32'd9);
      chk("eq_q_hold", {31'd0, eq_q}, 32'd1);
      step(1'b1, 1'b1, 32'd7, 32'd7);
      chk("rst_prio_eq_q", {31'd0, eq_q}, 32'd0);
      step(1'b0, 1'b1, 32'd7, 32'd7);
      chk("post_rst_eq_q", {31'd0, eq_q}, 32'd1);
      step(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001);
      step(1'b0, 1'b1, 32'h0000_0001, 32'h8000_0000);
      for (int i = 0; i < 200; i++) begin
         logic [31:0] a, b;
         a = $urandom();
         b = ($urandom_range(0, 3) == 0) ? a : $urandom();
         if ($urandom_range(0, 3) == 0) b[31] = a[31];
         step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, a, b);
         chk("rand_comb", {29'd0, Comparador_Salida, lt_u, lt_s}, {29'd0, model(a, b)});
      end
      chk("sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/comparador.md
Name: comparador

Overview:
- Equality and magnitude comparator for the processor's branch/compare path.
- Combinational equality flag `Comparador_Salida` is 1 when `reg1 == reg2`. It is used directly by branch-decision logic with no clock latency.
- Also provides a one-cycle registered copy of equality plus signed/unsigned less-than flags, with a valid strobe, for pipelined consumers.

Parameters:
- WIDTH, 32, operand width in bits (minimum 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- reg1  input  WIDTH  operand A.
- reg2  input  WIDTH  operand B.
- in_valid  input  1  operands are meaningful this cycle; captures the registered results.
- Comparador_Salida  output  1  combinational: 1 iff reg1 == reg2 (all bits).
- lt_u  output  1  combinational: 1 iff reg1 < reg2, unsigned.
- lt_s  output  1  combinational: 1 iff reg1 < reg2, two's-complement signed.
- eq_q  output  1  registered Comparador_Salida.
- lt_u_q  output  1  registered lt_u.
- lt_s_q  output  1  registered lt_s.
- out_valid  output  1  registered results correspond to an in_valid cycle.

Behaviour:
- Combinational outputs (Comparador_Salida, lt_u, lt_s):
  - Pure functions of reg1/reg2. Zero latency, no clock dependency.
  - Not affected by reset or in_valid.
  - Must settle within the same delta/timestep after an operand change.
- Equality is a bitwise compare across all WIDTH bits. Any single-bit difference (including MSB or LSB only) gives 0.
- lt_u: unsigned magnitude compare.
- lt_s: signed compare.
  - Operands with differing MSBs: the one with MSB=1 is smaller.
  - Operands with equal MSBs: result equals lt_u.
- Exactly one of {equal, lt_u, gt_u} holds at any time (unsigned). The same holds for the signed set.
- Registered path, on each rising clk:
  - If reset=1: eq_q=0, lt_u_q=0, lt_s_q=0, out_valid=0.
  - Else if in_valid=1: eq_q, lt_u_q, lt_s_q load the current combinational values; out_valid=1.
  - Else: eq_q, lt_u_q, lt_s_q hold their values; out_valid=0.
- Latency of the registered path is 1 cycle; throughput is one compare per cycle, back-to-back.
- Reset mid-stream: the reset cycle wins over in_valid. The next valid result appears one cycle after the first in_valid following reset deassertion.
- X/Z on operands is not supported; behaviour is undefined.

Decomposition:
- Shared package holds:
  - the WIDTH default constant (32);
  - a cmp_flags_t struct {eq, lt_u, lt_s}, used for the register bundle.
- One natural sub-module: comparador_core. It is the purely combinational eq/lt_u/lt_s logic.
- The top level, comparador, adds the output register stage and valid tracking.

Test Plan:
- Equal sweep: reg1=reg2=k for k=0..99, operands changed every 5 ns with no clock edge → Comparador_Salida=1 throughout; lt_u=0; lt_s=0.
- Off-by-one sweep: reg1=k, reg2=k+1 for k=0..99 → Comparador_Salida=0 throughout; lt_u=1; lt_s=1.
- Edge values, combinational outputs:

  | reg1 | reg2 | eq | lt_u | lt_s |
  |---|---|---|---|---|
  | 32'h0000_0000 | 32'h0000_0000 | 1 | 0 | 0 |
  | 32'hFFFF_FFFF | 32'hFFFF_FFFF | 1 | 0 | 0 |
  | 32'h8000_0000 | 32'h0000_0000 | 0 | 0 | 1 |
  | 32'h7FFF_FFFF | 32'h8000_0000 | 0 | 1 | 0 |
  | 32'hFFFF_FFFF | 32'h0000_0001 | 0 | 0 | 1 |

- Single-bit difference: reg2 = reg1 XOR (1<<i), for i=0..31, reg1=32'hA5A5_5A5A → Comparador_Salida=0 for every i.
- Registered path:
  - Hold reset for 2 cycles → all _q outputs and out_valid = 0.
  - Then, with in_valid=1 and reg1=reg2=5 on cycle N → eq_q=1, out_valid=1 after edge N.
  - Then in_valid=0 on cycle N+1 → out_valid=0, eq_q holds 1.
- Reset priority: assert reset and in_valid together with reg1=reg2=7 → after the edge, out_valid=0 and eq_q=0. Deassert reset with in_valid=1 → eq_q=1, out_valid=1 one cycle later.
